// File: rtl/aes_pkg.sv
// Shared AES definitions: geometry, state/column types, the round FSM
// encoding, and the GF(2^8) doubling helper used by MixColumns.
package aes_pkg;

  localparam int AES_NCOL = 4;
  localparam int AES_CW   = 32;

  typedef logic [AES_CW-1:0] aes_col_t;

  // Element [AES_NCOL-1] is the MSB column, i.e. AES column 0.
  typedef logic [AES_NCOL-1:0][AES_CW-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  // Multiply by x (0x02) in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/mixcolumn_gate.sv
// Combinational MixColumns transform of a single 32-bit column.
// Byte 0 of the column is the MSB byte.
module mixcolumn_gate
  import aes_pkg::*;
(
  input  aes_col_t x,
  output aes_col_t y
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] d0, d1, d2, d3;

  assign a0 = x[31:24];
  assign a1 = x[23:16];
  assign a2 = x[15:8];
  assign a3 = x[7:0];

  // Doubled bytes; tripling is doubling xor the byte itself.
  assign d0 = xtime(a0);
  assign d1 = xtime(a1);
  assign d2 = xtime(a2);
  assign d3 = xtime(a3);

  // Circulant matrix rows {2,3,1,1}.
  assign y[31:24] = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
  assign y[23:16] = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
  assign y[15:8]  = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
  assign y[7:0]   = (d0 ^ a0) ^ a1 ^ a2 ^ d3;

endmodule

// File: rtl/aes_mixcol_seq.sv
// Column-serial MixColumns engine: one 128-bit state per handshake, one
// column per cycle through a single shared gate, result held on out_*.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_valid is ignored while in_ready is low; in_state/in_bypass
// are sampled only on a transfer. Once out_valid rises it stays high with
// out_state stable until out_ready is seen. in_ready is combinational on
// out_ready in DONE so a new state can be taken on the same edge the result
// is consumed.
module aes_mixcol_seq
  import aes_pkg::*;
#(
  parameter int NCOL = AES_NCOL,
  parameter int CW   = AES_CW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCOL*CW-1:0] in_state,
  input  logic               in_bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCOL*CW-1:0] out_state,
  output logic               busy
);

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  aes_fsm_e   state_q;
  logic [1:0] col_cnt;
  aes_state_t buf_q;
  logic       byp_q;

  logic       accept;
  logic [1:0] col_idx;
  aes_col_t   gate_x;
  aes_col_t   gate_y;

  // Column c lives in packed element NCOL-1-c, which for a 2-bit counter is ~c.
  assign col_idx = ~col_cnt;
  assign gate_x  = buf_q[col_idx];

  mixcolumn_gate u_gate (
    .x (gate_x),
    .y (gate_y)
  );

  // Ready in IDLE, or in DONE when the held result is being consumed.
  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_state = buf_q;
  assign busy      = (state_q != IDLE);

  // Control FSM together with the state buffer and column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_cnt <= 2'd0;
      buf_q   <= '0;
      byp_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            buf_q   <= in_state;
            byp_q   <= in_bypass;
            col_cnt <= 2'd0;
            state_q <= in_bypass ? DONE : RUN;
          end
        end
        RUN: begin
          if (!byp_q) begin
            buf_q[col_idx] <= gate_y;
          end
          if (col_cnt == LAST_COL) begin
            col_cnt <= 2'd0;
            state_q <= DONE;
          end else begin
            col_cnt <= col_cnt + 2'd1;
          end
        end
        DONE: begin
          // buf_q is untouched here unless the result is consumed.
          if (out_ready) begin
            if (accept) begin
              buf_q   <= in_state;
              byp_q   <= in_bypass;
              col_cnt <= 2'd0;
              state_q <= in_bypass ? DONE : RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          col_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Self-checking bench for aes_mixcol_seq: directed FIPS-197, bypass,
// backpressure and reset scenarios plus randomized streams, all scored
// against a GF(2^8) matrix-multiply reference model.
module tb_aes_mixcol_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_checks;
  int n_fails;
  int cyc;

  logic [127:0] exp_q[$];
  int           out_cyc_q[$];

  logic         hold_v;
  logic [127:0] hold_s;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  aes_mixcol_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s, input logic byp);
    logic [127:0] r;
    logic [7:0]   a[4];
    logic [7:0]   coef[4];
    logic [7:0]   acc;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[k], coef[(k - row + 4) % 4]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge rst_n) begin
    exp_q.delete();
    hold_v = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_v) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_state", out_state, hold_s);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_state, in_bypass));
      if (out_valid && out_ready) begin
        chk("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("out_state", out_state, exp_q.pop_front());
        out_cyc_q.push_back(cyc);
      end
      hold_v = out_valid && !out_ready;
      hold_s = out_state;
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one state and return once the handshake edge has passed.
  task automatic send(input logic [127:0] s, input logic byp);
    bit hs;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
    hs = 1'b0;
    for (int g = 0; g < 200 && !hs; g++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
    end
    chk("send_handshake", hs, 1'b1);
    in_valid = 1'b0;
  endtask

  // Count edges from the handshake edge to the first cycle with out_valid.
  task automatic wait_out(output int edges);
    bit seen;
    edges = 1;
    seen  = 1'b0;
    for (int g = 0; g < 100 && !seen; g++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    chk("out_valid_seen", seen, 1'b1);
  endtask

  task automatic drain();
    bit done;
    out_ready = 1'b1;
    done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int sent;
    bit hs;
    logic [127:0] held;

    n_checks = 0; n_fails = 0; cyc = 0;
    hold_v = 1'b0; hold_s = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_bypass = 1'b0; out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, '0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // FIPS-197 column vector.
    send(FIPS_IN, 1'b0);
    wait_out(lat);
    chk("fips_latency", lat, 5);
    chk("fips_state", out_state, FIPS_OUT);
    chk("fips_model", ref_model(FIPS_IN, 1'b0), FIPS_OUT);
    drain();

    // Bypass.
    send(BYP_IN, 1'b1);
    wait_out(lat);
    chk("byp_latency", lat, 1);
    chk("byp_state", out_state, BYP_IN);
    drain();

    // Backpressure.
    out_ready = 1'b0;
    send(rand128(), 1'b0);
    wait_out(lat);
    chk("bp_latency", lat, 5);
    held = out_state;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", out_state, held);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_released", out_valid, 1'b0);
    drain();

    // Back-to-back: in_valid held high for 8 random states.
    out_cyc_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1; in_bypass = 1'b0; in_state = rand128();
    sent = 0;
    for (int g = 0; g < 500 && sent < 8; g++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        if (sent < 8) in_state = rand128();
        else in_valid = 1'b0;
      end
    end
    drain();
    chk("b2b_count", out_cyc_q.size(), 8);
    for (int i = 1; i < out_cyc_q.size(); i++)
      chk("b2b_spacing", out_cyc_q[i] - out_cyc_q[i-1], 5);

    // Reset in the middle of RUN, after the second column.
    send(FIPS_IN, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rrun_out_valid", out_valid, 1'b0);
    chk("rrun_busy", busy, 1'b0);
    chk("rrun_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rrun_idle_ready", in_ready, 1'b1);
    chk("rrun_idle_busy", busy, 1'b0);
    send(FIPS_IN, 1'b0);
    wait_out(lat);
    chk("rrun_fips_latency", lat, 5);
    chk("rrun_fips_state", out_state, FIPS_OUT);
    drain();

    // Reset while a result is held in DONE.
    out_ready = 1'b0;
    send(BYP_IN, 1'b1);
    wait_out(lat);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rdone_out_valid", out_valid, 1'b0);
    chk("rdone_out_state", out_state, '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rdone_idle_ready", in_ready, 1'b1);

    // Mixed bypass/normal stream under random out_ready.
    @(posedge clk); #1;
    sent = 0;
    for (int g = 0; g < 3000 && sent < 40; g++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 40 && ($urandom_range(0, 1) == 1)) begin
        in_valid  = 1'b1;
        in_state  = rand128();
        in_bypass = ($urandom_range(0, 2) == 0);
      end
    end
    in_valid = 1'b0;
    chk("mix_sent", sent, 40);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
